// File: rtl/uart_frame_parser.sv
// Byte-level SOF/LEN/payload/XOR-checksum frame parser placed after the UART receiver.
// Optional inter-byte timeout is enabled by defining FRAME_TIMEOUT_EN.
module uart_frame_parser #(
    parameter int         MAX_LEN        = 8,
    parameter logic [7:0] SOF            = 8'h23,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk_50M,
    input  logic                 rst_n,
    input  logic [7:0]           rx_msg,
    input  logic                 rx_complete,
    output logic [8*MAX_LEN-1:0] frame_data,
    output logic [3:0]           frame_len,
    output logic                 frame_valid,
    output logic                 frame_err,
    output logic [1:0]           err_code,
    output logic                 frame_busy
);

    typedef enum logic [1:0] {
        IDLE,
        LEN_S,
        PAY,
        CSUM_S
    } state_t;

    state_t               state, state_next;
    logic [3:0]           len, len_next;
    logic [3:0]           idx, idx_next;
    logic [7:0]           csum, csum_next;
    logic [8*MAX_LEN-1:0] shadow, shadow_next;
    logic [8*MAX_LEN-1:0] data_next;
    logic [3:0]           flen_next;
    logic [1:0]           code_next;
    logic                 valid_next;
    logic                 err_next;
    logic                 timeout;

`ifdef FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timer;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (rx_complete || state == IDLE) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout = (state != IDLE) && !rx_complete &&
                     (timer == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;

    assign unused_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout    = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        len_next    = len;
        idx_next    = idx;
        csum_next   = csum;
        shadow_next = shadow;
        data_next   = frame_data;
        flen_next   = frame_len;
        code_next   = err_code;
        valid_next  = 1'b0;
        err_next    = 1'b0;

        if (rx_complete) begin
            unique case (state)
                IDLE: begin
                    if (rx_msg == SOF) begin
                        state_next = LEN_S;
                    end
                end
                LEN_S: begin
                    if (rx_msg == 8'd0 || rx_msg > 8'(MAX_LEN)) begin
                        err_next   = 1'b1;
                        code_next  = 2'd1;
                        state_next = IDLE;
                    end else begin
                        len_next    = rx_msg[3:0];
                        csum_next   = rx_msg;
                        idx_next    = '0;
                        shadow_next = '0;
                        state_next  = PAY;
                    end
                end
                PAY: begin
                    shadow_next[8*idx +: 8] = rx_msg;
                    csum_next               = csum ^ rx_msg;
                    idx_next                = idx + 4'd1;
                    if (idx == len - 4'd1) begin
                        state_next = CSUM_S;
                    end
                end
                CSUM_S: begin
                    // Only a verified frame reaches the command layer's view.
                    if (rx_msg == csum) begin
                        data_next  = shadow;
                        flen_next  = len;
                        valid_next = 1'b1;
                    end else begin
                        err_next  = 1'b1;
                        code_next = 2'd2;
                    end
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end else if (timeout) begin
            err_next   = 1'b1;
            code_next  = 2'd3;
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            len         <= '0;
            idx         <= '0;
            csum        <= '0;
            shadow      <= '0;
            frame_data  <= '0;
            frame_len   <= '0;
            err_code    <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_next;
            len         <= len_next;
            idx         <= idx_next;
            csum        <= csum_next;
            shadow      <= shadow_next;
            frame_data  <= data_next;
            frame_len   <= flen_next;
            err_code    <= code_next;
            frame_valid <= valid_next;
            frame_err   <= err_next;
        end
    end

    assign frame_busy = (state != IDLE);

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-level framing stage directly downstream of the UART receiver. Consumes each received byte (`rx_msg` qualified by the one-cycle `rx_complete` pulse) and assembles SOF/length/payload/checksum frames. Emits a registered one-cycle `frame_valid` with the payload and length, or a one-cycle `frame_err` with a cause code, to the command layer.

## Interface
- `MAX_LEN`, 8: maximum payload bytes per frame, range 1..15.
- `SOF`, 8'h23: start-of-frame byte.
- `TIMEOUT_CYCLES`, 50000: inter-byte timeout in clocks, about 1 ms at 50 MHz. Used only with `FRAME_TIMEOUT_EN`.

Ports:
- `clk_50M` input 1: 50 MHz clock, all logic on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `rx_msg` input 8: received byte, valid only when `rx_complete`=1.
- `rx_complete` input 1: one-cycle byte strobe.
- `frame_data` output 8*MAX_LEN: payload; byte i at bits [8i+7:8i].
- `frame_len` output 4: payload length of the last good frame.
- `frame_valid` output 1: one-cycle pulse, good frame.
- `frame_err` output 1: one-cycle pulse, frame aborted.
- `err_code` output 2: cause of the last error. 1 = bad length, 2 = checksum, 3 = timeout.
- `frame_busy` output 1: high whenever state is not IDLE.

## Operation
- Reset values: all outputs 0, state IDLE, internal index/checksum/timer 0.
- Frame on the wire: SOF, LEN (1..MAX_LEN), LEN payload bytes, CSUM = XOR of LEN and all payload bytes.
- States and transitions. Each transition happens only on a clock with `rx_complete`=1, except timeout.
  - IDLE
    - Byte == SOF → LEN_S.
    - Any other byte is discarded silently; no error.
  - LEN_S
    - Byte == 0 or byte > MAX_LEN → `frame_err`, `err_code`=1, → IDLE.
    - Otherwise latch the length, csum := byte, idx := 0, clear the payload shadow register to 0, → PAY.
  - PAY
    - shadow[idx] := byte, csum ^= byte, idx++.
    - When idx == len-1 before the increment → CSUM_S.
  - CSUM_S
    - Byte == csum → copy the shadow to `frame_data` and the length to `frame_len`, pulse `frame_valid`.
    - Otherwise pulse `frame_err`, `err_code`=2.
    - Either way → IDLE.
- Unused upper payload bytes of `frame_data` are 0.
- A SOF value received inside LEN_S/PAY/CSUM_S is treated as data, not as a resync.
- `frame_data`, `frame_len` and `err_code` hold their values until the next valid or error event.
- Payload is loaded into `frame_data` only on a good checksum. A bad frame never disturbs the previous good frame.

## Timing
- `rx_complete` high at edge k → state update at edge k.
- `frame_valid`/`frame_err` high for exactly the cycle following edge k; outputs are registered.
- `frame_data`/`frame_len`/`err_code` update on the same edge as their pulse.
- Back-to-back `rx_complete` on consecutive cycles must be accepted. There is no minimum byte spacing.
- `frame_valid` and `frame_err` are never high together.
- Reset asserted mid-frame: immediately IDLE, partial frame dropped, no pulse.

## Configuration
- `FRAME_TIMEOUT_EN` defined:
  - The inter-byte timer clears on every `rx_complete` and in IDLE, and counts while not IDLE.
  - On reaching TIMEOUT_CYCLES-1 with no byte: `frame_err`, `err_code`=3, → IDLE.
  - If timeout and `rx_complete` occur on the same cycle, the byte wins and the timer clears.
- `FRAME_TIMEOUT_EN` undefined:
  - No timer logic.
  - A partial frame waits indefinitely.
  - `err_code`=3 never occurs.

## Test plan
- Good frame: send 23,02,41,42,01 → one `frame_valid`, `frame_len`=2, `frame_data`=64'h0000_0000_0000_4241, `frame_busy` low afterwards.
- Bad checksum: send 23,01,55,00 → `frame_err`, `err_code`=2. `frame_data`/`frame_len` still hold the previous good frame.
- Bad length: send 23,09 (MAX_LEN=8) → `frame_err`, `err_code`=1. Then 23,01,AA,AB → `frame_valid`, `frame_data` low byte AA.
- Noise plus back-to-back: send 00,FF,23,01,23,22 on consecutive clocks → noise ignored, one `frame_valid` with payload 23 (SOF accepted as data).
- Timeout (macro on, TIMEOUT_CYCLES=100): send 23,03,10, then idle 100 clocks → `frame_err`, `err_code`=3, IDLE. A byte arriving exactly on cycle 99 instead → no error.
- Reset mid-frame: send 23,02,41, pulse `rst_n` low → all outputs 0. Then a full good frame parses normally.
